// File: rtl/fixmul_pkg.sv
// Shared widths, state encoding and helpers for the Q1.15 sequential multiplier.
package fixmul_pkg;
  localparam int W    = 16;
  localparam int FRAC = 15;
  localparam int CW   = $clog2(W);

  localparam logic [W-1:0] Q1_15_MAX = 16'h7FFF;

  typedef enum logic [2:0] {IDLE, LOAD, CALC, FIN, DONE} state_t;

  // Two's complement magnitude; 0x8000 maps to 0x8000 as an unsigned value.
  function automatic logic [W-1:0] mag(input logic [W-1:0] v);
    return v[W-1] ? (~v + W'(1)) : v;
  endfunction
endpackage

// File: rtl/fixmul_dp.sv
// Datapath: operand latches, shift-add accumulator, step counter and sign/saturate output stage.
module fixmul_dp
  import fixmul_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         cap,
  input  logic         ld,
  input  logic         step,
  input  logic         fin,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  output logic         cnt_last,
  output logic [W-1:0] out
);
  logic [W-1:0]   a_lat, b_lat;
  logic           sign;
  logic [W-1:0]   mag_a, mag_b;
  logic [2*W-1:0] acc;
  logic [CW-1:0]  cnt;
  logic [W-1:0]   out_reg;

  logic [2*W-1:0] addend;
  logic [W:0]     p;
  logic [W-1:0]   res;

  assign cnt_last = (cnt == CW'(W - 1));
  assign out      = out_reg;

  always_comb begin
    addend = '0;
    if (mag_b[cnt])
      addend = {{W{1'b0}}, mag_a} << cnt;
  end

  // Magnitude truncation toward zero; only -1 x -1 can exceed the positive range.
  always_comb begin
    p = acc[2*W-1:FRAC];
    if (!sign && (p > {1'b0, Q1_15_MAX}))
      res = Q1_15_MAX;
    else if (sign)
      res = ~p[W-1:0] + W'(1);
    else
      res = p[W-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_lat   <= '0;
      b_lat   <= '0;
      sign    <= 1'b0;
      mag_a   <= '0;
      mag_b   <= '0;
      acc     <= '0;
      cnt     <= '0;
      out_reg <= '0;
    end else if (clr) begin
      a_lat   <= '0;
      b_lat   <= '0;
      sign    <= 1'b0;
      mag_a   <= '0;
      mag_b   <= '0;
      acc     <= '0;
      cnt     <= '0;
      out_reg <= '0;
    end else begin
      // Operands are latched on the accepting edge so A/B may change afterwards.
      if (cap) begin
        a_lat <= A;
        b_lat <= B;
      end
      if (ld) begin
        sign  <= a_lat[W-1] ^ b_lat[W-1];
        mag_a <= mag(a_lat);
        mag_b <= mag(b_lat);
        acc   <= '0;
        cnt   <= '0;
      end
      if (step) begin
        acc <= acc + addend;
        cnt <= cnt + CW'(1);
      end
      if (fin)
        out_reg <= res;
    end
  end
endmodule

// File: rtl/fixmul_top.sv
// Sequential signed Q1.15 multiplier: start/done handshake FSM driving the shift-add datapath.
module fixmul_top
  import fixmul_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         rst_begin,
  input  logic         start,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  output logic         done,
  output logic [W-1:0] out
);
  state_t state;
  logic   done_reg;
  logic   cap, ld, step, fin, cnt_last;

  assign cap  = ((state == IDLE) || (state == DONE)) && start;
  assign ld   = (state == LOAD);
  assign step = (state == CALC);
  assign fin  = (state == FIN);
  assign done = done_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      done_reg <= 1'b0;
    end else if (rst_begin) begin
      state    <= IDLE;
      done_reg <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) state <= LOAD;
        LOAD: state <= CALC;
        CALC: if (cnt_last) state <= FIN;
        FIN: begin
          state    <= DONE;
          done_reg <= 1'b1;
        end
        DONE: if (start) begin
          state    <= LOAD;
          done_reg <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  fixmul_dp u_dp (
    .clk      (clk),
    .rst      (rst),
    .clr      (rst_begin),
    .cap      (cap),
    .ld       (ld),
    .step     (step),
    .fin      (fin),
    .A        (A),
    .B        (B),
    .cnt_last (cnt_last),
    .out      (out)
  );
endmodule

// File: tb/tb_fixmul_top.sv
// Directed self-checking bench for fixmul_top with hand-computed Q1.15 products.
module tb_fixmul_top;
  logic        clk = 1'b0;
  logic        rst;
  logic        rst_begin;
  logic        start;
  logic [15:0] A, B;
  logic        done;
  logic [15:0] out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fixmul_top dut (
    .clk       (clk),
    .rst       (rst),
    .rst_begin (rst_begin),
    .start     (start),
    .A         (A),
    .B         (B),
    .done      (done),
    .out       (out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s = %0h", tag, obs);
    end
  endtask

  // One transaction: start pulse, operands scrambled after the accept edge,
  // optional ignored start pulse during CALC, latency and result checked.
  task automatic do_mul(input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] exp, input string tag, input bit poke);
    int n;
    @(negedge clk);
    A = a; B = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0; A = 16'h5A5A; B = 16'hA5A5;
    check({tag, "_done_low"}, 32'(done), 32'd0);
    n = 0;
    while (!done && n < 40) begin
      if (poke && n == 5) begin
        start = 1'b1; A = 16'h7FFF; B = 16'h7FFF;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    check({tag, "_latency"}, 32'(n), 32'd18);
    check({tag, "_out"}, 32'(out), 32'(exp));
  endtask

  initial begin
    int n;
    rst = 1'b0; rst_begin = 1'b0; start = 1'b0; A = '0; B = '0;
    #12;
    check("reset_done", 32'(done), 32'd0);
    check("reset_out", 32'(out), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    do_mul(16'h4000, 16'h5000, 16'h2800, "half_x_5_8", 1'b0);
    do_mul(16'hC000, 16'h4000, 16'hE000, "neg_half_x_half", 1'b0);
    repeat (3) @(negedge clk);
    check("hold_done", 32'(done), 32'd1);
    check("hold_out", 32'(out), 32'hE000);
    do_mul(16'h8000, 16'h7FFF, 16'h8001, "m1_x_max", 1'b0);
    do_mul(16'h8000, 16'h8000, 16'h7FFF, "m1_x_m1_sat", 1'b0);
    do_mul(16'h0001, 16'h0001, 16'h0000, "lsb_x_lsb", 1'b0);
    do_mul(16'h7FFF, 16'h7FFF, 16'h7FFE, "max_x_max", 1'b0);
    do_mul(16'hFFFF, 16'h4000, 16'h0000, "trunc_to_zero", 1'b0);
    do_mul(16'h0003, 16'hC000, 16'hFFFF, "trunc_neg", 1'b0);
    do_mul(16'h0000, 16'h8000, 16'h0000, "zero_x_m1", 1'b0);
    do_mul(16'h2000, 16'h2000, 16'h0800, "calc_start_ignored", 1'b1);

    // Soft clear in the middle of CALC while the previous result is still shown.
    @(negedge clk);
    A = 16'h4000; B = 16'h4000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (n = 0; n < 5; n++) @(negedge clk);
    rst_begin = 1'b1;
    @(negedge clk);
    rst_begin = 1'b0;
    check("soft_clr_done", 32'(done), 32'd0);
    check("soft_clr_out", 32'(out), 32'd0);
    repeat (25) @(negedge clk);
    check("soft_clr_stays_idle", 32'(done), 32'd0);
    do_mul(16'h6000, 16'h6000, 16'h4800, "after_soft_clr", 1'b0);

    // Asynchronous reset while in DONE, sampled before the next rising edge.
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("async_rst_done", 32'(done), 32'd0);
    check("async_rst_out", 32'(out), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    do_mul(16'hA000, 16'h4000, 16'hD000, "after_async_rst", 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
